lane_sprite_plotter: RTL

Parametrised lane-based sprite mover and plotter for the 160x120 VGA car game. It sits between the keyboard/speed blocks and the vga_adapter. It keeps the car's lane index, and on each speed tick applies any latched left/right request. It then erases the old sprite footprint by re-plotting background memory and draws the sprite at the new lane. Sprite and background memories are external, one-cycle-latency synchronous ROMs.

---
 rtl/lane_sprite_plotter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lane_sprite_plotter.sv
// lane_sprite_plotter
//
// Keeps the car sprite in one of LANES horizontal lanes. When a speed tick
// is consumed with a valid latched left/right request, it erases the old
// footprint by replotting background ROM pixels. It then draws the sprite
// ROM at the new lane. After reset release it draws the sprite once at
// START_LANE.
//
// State table
//   state   | meaning
//   INIT    | draw pass at START_LANE after reset release
//   IDLE    | waiting for a tick; latched requests are resolved here
//   ERASE   | background replot of the old lane footprint
//   DRAW    | sprite plot at the new lane (lane already updated)
//   FLUSH   | last pixel leaves the output stage, done pulses
//
// Ports
//   Clock, Resetn        system clock, async active-low reset
//   tick, left, right    movement enable and one-cycle direction pulses
//   spr_addr / spr_data  sprite ROM address {cy,cx}, data one cycle later
//   bg_x, bg_y / bg_data background ROM coordinate, data one cycle later
//   vga_x, vga_y, vga_colour, plot   pixel write to vga_adapter
//   lane                 current lane index
//   busy                 pass in progress
//   done                 one-cycle pulse with the final pixel of a pass
module lane_sprite_plotter #(
  parameter int SPR_WB     = 3,
  parameter int SPR_HB     = 3,
  parameter int LANES      = 3,
  parameter int START_LANE = 1,
  parameter int LANE0_X    = 40,
  parameter int LANE_STEP  = 35,
  parameter int Y_POS      = 70,
  parameter int CB         = 3,
  parameter int TRANSP_EN  = 0,
  parameter int TRANSP_COL = 0
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         tick,
  input  logic                         left,
  input  logic                         right,
  output logic [SPR_HB+SPR_WB-1:0]     spr_addr,
  input  logic [CB-1:0]                spr_data,
  output logic [7:0]                   bg_x,
  output logic [6:0]                   bg_y,
  input  logic [CB-1:0]                bg_data,
  output logic [7:0]                   vga_x,
  output logic [6:0]                   vga_y,
  output logic [CB-1:0]                vga_colour,
  output logic                         plot,
  output logic [$clog2(LANES)-1:0]     lane,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(LANES);
  localparam int AW = SPR_HB + SPR_WB;
  localparam logic [AW-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [LW-1:0]   new_lane_q, new_lane_d;
  logic            pend_l_q, pend_l_d;
  logic            pend_r_q, pend_r_d;
  logic            run_q, run_d;
  logic            valid_q, valid_d;
  logic            draw_q, draw_d;
  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;

  logic            active;
  logic            consume;
  logic            want_l, want_r;
  logic            at_lo, at_hi;
  logic            transparent;
  logic [SPR_WB-1:0] cx;
  logic [SPR_HB-1:0] cy;
  logic [7:0]      base_x;
  logic [7:0]      pix_x;
  logic [6:0]      pix_y;

  // run_q holds the address outputs at zero while reset is asserted, even
  // though the state register already sits in INIT with a zero counter.
  assign active = run_q && ((state_q == S_INIT) || (state_q == S_ERASE) ||
                            (state_q == S_DRAW));

  assign cx = cnt_q[SPR_WB-1:0];
  assign cy = cnt_q[AW-1:SPR_WB];

  // lane_q is the old lane during ERASE and the new lane during DRAW, so it
  // selects the footprint directly.
  always_comb begin
    base_x = 8'(LANE0_X + 32'(lane_q) * LANE_STEP);
    pix_x  = base_x + 8'(cx);
    pix_y  = 7'(Y_POS) + 7'(cy);
  end

  assign spr_addr = active ? cnt_q : '0;
  assign bg_x     = active ? pix_x : 8'd0;
  assign bg_y     = active ? pix_y : 7'd0;

  // Opposite requests cancel, whether they arrived together or separately.
  assign want_l = pend_l_q && !pend_r_q;
  assign want_r = pend_r_q && !pend_l_q;
  assign at_lo  = (lane_q == '0);
  assign at_hi  = (lane_q == LW'(LANES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    new_lane_d = new_lane_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    run_d      = 1'b1;
    consume    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (run_q) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == CNT_LAST) state_d = S_FLUSH;
        end
      end
      S_IDLE: begin
        if (tick) begin
          consume = 1'b1;
          if (want_l && !at_lo) begin
            new_lane_d = lane_q - LW'(1);
            cnt_d      = '0;
            state_d    = S_ERASE;
          end else if (want_r && !at_hi) begin
            new_lane_d = lane_q + LW'(1);
            cnt_d      = '0;
            state_d    = S_ERASE;
          end
        end
      end
      S_ERASE: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAW;
          lane_d  = new_lane_q;
        end
      end
      S_DRAW: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pulse in the same cycle as a consumed tick survives for the next one.
    if (consume) begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end
    if (left && !right) pend_l_d = 1'b1;
    if (right && !left) pend_r_d = 1'b1;
  end

  always_comb begin
    valid_d = active;
    draw_d  = (state_q == S_INIT) || (state_q == S_DRAW);
    vga_x_d = bg_x;
    vga_y_d = bg_y;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      lane_q     <= LW'(START_LANE);
      new_lane_q <= LW'(START_LANE);
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      run_q      <= 1'b0;
      valid_q    <= 1'b0;
      draw_q     <= 1'b0;
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      new_lane_q <= new_lane_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      run_q      <= run_d;
      valid_q    <= valid_d;
      draw_q     <= draw_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
    end
  end

  // ROM data arrives in the cycle the output stage holds its coordinate.
  assign transparent = (TRANSP_EN != 0) && draw_q && (spr_data == CB'(TRANSP_COL));

  assign plot       = valid_q && !transparent;
  assign vga_colour = !valid_q ? '0 : (draw_q ? spr_data : bg_data);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign lane       = lane_q;
  assign busy       = run_q && (state_q != S_IDLE);
  assign done       = (state_q == S_FLUSH);

endmodule
